// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared helpers for the single-clock FIFO:
//   ptr_w(depth) - pointer width, at least 1 bit even for tiny depths
//   cnt_w(depth) - occupancy counter width, able to hold 0..depth
//   FIFO_STD / FIFO_FWFT - read-mode selectors for the FWFT parameter
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Pointer width; clamped to 1 so a pointer is never a zero-width vector.
  function automatic int ptr_w(input int depth);
    int w;
    w = $clog2(depth);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  // Counter width: must represent the value 'depth' itself (full).
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// -----------------------------------------------------------------------------
// sync_fifo_ram
// Simple dual-port storage array, DATA_WIDTH x FIFO_DEPTH.
// One synchronous write port, one asynchronous (combinational) read port.
// Contents are intentionally not reset.
// Ports:
//   clk        - write clock
//   i_wr_en    - write strobe (already qualified by the controller)
//   i_wr_addr  - write address, 0..FIFO_DEPTH-1
//   i_wr_data  - write word
//   i_rd_addr  - read address, 0..FIFO_DEPTH-1
//   o_rd_data  - word at i_rd_addr
// -----------------------------------------------------------------------------
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             i_wr_en,
  input  logic [ptr_w(FIFO_DEPTH)-1:0]     i_wr_addr,
  input  logic [DATA_WIDTH-1:0]            i_wr_data,
  input  logic [ptr_w(FIFO_DEPTH)-1:0]     i_rd_addr,
  output logic [DATA_WIDTH-1:0]            o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock parametrised FIFO with occupancy count, almost-full/empty
// thresholds, sticky overflow/underflow flags and selectable FWFT read mode.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   wr_en, wr_data  - write request and word (dropped while full)
//   rd_en, rd_data  - read request and word (dropped while empty)
//   full, empty, almost_full, almost_empty - decoded from the count register
//   count           - current occupancy 0..FIFO_DEPTH
//   err_clr         - clears the sticky error flags
//   overflow        - sticky: write attempted while full
//   underflow       - sticky: read attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = FIFO_STD
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           rd_en,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           full,
  output logic                           empty,
  output logic                           almost_full,
  output logic                           almost_empty,
  output logic [cnt_w(FIFO_DEPTH)-1:0]   count,
  input  logic                           err_clr,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int AW = ptr_w(FIFO_DEPTH);
  localparam int CW = cnt_w(FIFO_DEPTH);

  localparam logic [AW-1:0] PTR_LAST = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_THRESH);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_THRESH);

  // Elaboration-time parameter checks.
  if (DATA_WIDTH < 1) begin : g_chk_dw
    $error("sync_fifo: DATA_WIDTH must be >= 1");
  end
  if (FIFO_DEPTH < 2) begin : g_chk_depth
    $error("sync_fifo: FIFO_DEPTH must be >= 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > FIFO_DEPTH)) begin : g_chk_af
    $error("sync_fifo: AF_THRESH must be in 1..FIFO_DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH > FIFO_DEPTH - 1)) begin : g_chk_ae
    $error("sync_fifo: AE_THRESH must be in 0..FIFO_DEPTH-1");
  end
  if ((FWFT != FIFO_STD) && (FWFT != FIFO_FWFT)) begin : g_chk_fwft
    $error("sync_fifo: FWFT must be 0 or 1");
  end

  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [DATA_WIDTH-1:0] w_ram_rd_data;

  // Explicit wrap: depth need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    logic [AW-1:0] n;
    if (p == PTR_LAST) begin
      n = {AW{1'b0}};
    end else begin
      n = p + AW'(1'b1);
    end
    return n;
  endfunction

  // Status decodes from the count register only, so no combinational path
  // exists from wr_en/rd_en to any flag.
  assign w_full       = (r_count == CNT_FULL);
  assign w_empty      = (r_count == {CW{1'b0}});
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= CNT_AF);
  assign almost_empty = (r_count <= CNT_AE);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // Acceptance uses pre-edge state: a simultaneous read does not make room
  // for a write into a full FIFO, and vice versa for an empty one.
  assign w_wr_acc = wr_en && !w_full;
  assign w_rd_acc = rd_en && !w_empty;

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (wr_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_ram_rd_data)
  );

  // Write and read pointer advance on accepted transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
    end
  end

  // Occupancy counter; holds when both or neither transfer is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {CW{1'b0}};
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1'b1);
        2'b01:   r_count <= r_count - CW'(1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; a new error event wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && w_full) begin
        r_overflow <= 1'b1;
      end else if (err_clr) begin
        r_overflow <= 1'b0;
      end
      if (rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end else if (err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  if (FWFT == FIFO_FWFT) begin : g_fwft
    // Head word is presented directly; forced to zero while empty so an
    // unwritten location is never visible.
    assign rd_data = w_empty ? {DATA_WIDTH{1'b0}} : w_ram_rd_data;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Read register, loaded only on an accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rd_data <= {DATA_WIDTH{1'b0}};
      end else if (w_rd_acc) begin
        r_rd_data <= w_ram_rd_data;
      end
    end

    assign rd_data = r_rd_data;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
// Directed bench for sync_fifo: one standard-mode instance (depth 5, AF 3,
// AE 2) and one FWFT instance (depth 5). Inputs change 1 time unit after the
// rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       s_wr_en = 1'b0;
  logic [7:0] s_wr_data = 8'h00;
  logic       s_rd_en = 1'b0;
  logic       s_err_clr = 1'b0;
  logic [7:0] s_rd_data;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [2:0] s_count;

  logic       f_wr_en = 1'b0;
  logic [7:0] f_wr_data = 8'h00;
  logic       f_rd_en = 1'b0;
  logic       f_err_clr = 1'b0;
  logic [7:0] f_rd_data;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [2:0] f_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sync_fifo #(
    .DATA_WIDTH (8), .FIFO_DEPTH (5), .AF_THRESH (3), .AE_THRESH (2), .FWFT (0)
  ) u_std (
    .clk (clk), .rst_n (rst_n), .wr_en (s_wr_en), .wr_data (s_wr_data),
    .rd_en (s_rd_en), .rd_data (s_rd_data), .full (s_full), .empty (s_empty),
    .almost_full (s_af), .almost_empty (s_ae), .count (s_count),
    .err_clr (s_err_clr), .overflow (s_ovf), .underflow (s_unf)
  );

  sync_fifo #(
    .DATA_WIDTH (8), .FIFO_DEPTH (5), .AF_THRESH (3), .AE_THRESH (2), .FWFT (1)
  ) u_fwft (
    .clk (clk), .rst_n (rst_n), .wr_en (f_wr_en), .wr_data (f_wr_data),
    .rd_en (f_rd_en), .rd_data (f_rd_data), .full (f_full), .empty (f_empty),
    .almost_full (f_af), .almost_empty (f_ae), .count (f_count),
    .err_clr (f_err_clr), .overflow (f_ovf), .underflow (f_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    #2;
    chk("rst_count", 32'(s_count), 32'd0);
    chk("rst_empty", 32'(s_empty), 32'd1);
    chk("rst_full",  32'(s_full),  32'd0);
    chk("rst_af",    32'(s_af),    32'd0);
    chk("rst_ae",    32'(s_ae),    32'd1);
    chk("rst_ovf",   32'(s_ovf),   32'd0);
    chk("rst_unf",   32'(s_unf),   32'd0);
    chk("rst_rdata", 32'(s_rd_data), 32'd0);
    chk("rst_f_empty", 32'(f_empty), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---------------- fill 0x11..0x55 ----------------
    for (int i = 1; i <= 5; i++) begin
      s_wr_en = 1'b1;
      s_wr_data = 8'(i * 8'h11);
      tick();
      chk($sformatf("fill_count%0d", i), 32'(s_count), 32'(i));
      chk($sformatf("fill_af%0d", i),    32'(s_af),    32'(i >= 3));
      chk($sformatf("fill_ae%0d", i),    32'(s_ae),    32'(i <= 2));
      chk($sformatf("fill_full%0d", i),  32'(s_full),  32'(i == 5));
    end
    s_wr_en = 1'b0;
    chk("fill_empty", 32'(s_empty), 32'd0);

    // ---------------- drain ----------------
    for (int i = 1; i <= 5; i++) begin
      s_rd_en = 1'b1;
      tick();
      chk($sformatf("drain_data%0d", i),  32'(s_rd_data), 32'(i * 8'h11));
      chk($sformatf("drain_count%0d", i), 32'(s_count),   32'(5 - i));
    end
    s_rd_en = 1'b0;
    tick();
    chk("drain_empty", 32'(s_empty),   32'd1);
    chk("drain_hold",  32'(s_rd_data), 32'h55);
    chk("drain_unf",   32'(s_unf),     32'd0);

    // ---------------- alternating pairs across pointer wrap ----------------
    for (int i = 0; i < 12; i++) begin
      s_wr_en = 1'b1;
      s_wr_data = 8'(8'hA0 + i);
      tick();
      s_wr_en = 1'b0;
      chk($sformatf("alt_wcount%0d", i), 32'(s_count), 32'd1);
      s_rd_en = 1'b1;
      tick();
      s_rd_en = 1'b0;
      chk($sformatf("alt_data%0d", i),   32'(s_rd_data), 32'(8'hA0 + i));
      chk($sformatf("alt_rcount%0d", i), 32'(s_count),   32'd0);
    end

    // ---------------- simultaneous write+read streaming ----------------
    s_wr_en = 1'b1;
    s_wr_data = 8'hC0;
    tick();
    for (int i = 1; i <= 6; i++) begin
      s_wr_en = 1'b1;
      s_rd_en = 1'b1;
      s_wr_data = 8'(8'hC0 + i);
      tick();
      chk($sformatf("stream_data%0d", i),  32'(s_rd_data), 32'(8'hC0 + i - 1));
      chk($sformatf("stream_count%0d", i), 32'(s_count),   32'd1);
    end
    s_wr_en = 1'b0;
    tick();
    s_rd_en = 1'b0;
    chk("stream_last",  32'(s_rd_data), 32'hC6);
    chk("stream_empty", 32'(s_empty),   32'd1);

    // ---------------- overflow with simultaneous read ----------------
    for (int i = 1; i <= 5; i++) begin
      s_wr_en = 1'b1;
      s_wr_data = 8'(i);
      tick();
    end
    chk("ovf_full", 32'(s_full), 32'd1);
    s_wr_data = 8'hEE;
    s_rd_en = 1'b1;
    tick();
    s_wr_en = 1'b0;
    s_rd_en = 1'b0;
    chk("ovf_rdata", 32'(s_rd_data), 32'h01);
    chk("ovf_count", 32'(s_count),   32'd4);
    chk("ovf_flag",  32'(s_ovf),     32'd1);
    tick();
    chk("ovf_sticky", 32'(s_ovf), 32'd1);
    s_err_clr = 1'b1;
    tick();
    s_err_clr = 1'b0;
    chk("ovf_clr", 32'(s_ovf), 32'd0);
    for (int i = 2; i <= 5; i++) begin
      s_rd_en = 1'b1;
      tick();
      chk($sformatf("ovf_drain%0d", i), 32'(s_rd_data), 32'(i));
    end
    s_rd_en = 1'b0;
    chk("ovf_drain_empty", 32'(s_empty), 32'd1);

    // ---------------- underflow with simultaneous write ----------------
    s_rd_en = 1'b1;
    s_wr_en = 1'b1;
    s_wr_data = 8'h7E;
    tick();
    s_wr_en = 1'b0;
    chk("unf_flag",  32'(s_unf),     32'd1);
    chk("unf_count", 32'(s_count),   32'd1);
    chk("unf_hold",  32'(s_rd_data), 32'h05);
    tick();
    s_rd_en = 1'b0;
    chk("unf_data",  32'(s_rd_data), 32'h7E);
    chk("unf_empty", 32'(s_empty),   32'd1);
    // Error event and clear in the same cycle: the flag stays set.
    s_rd_en = 1'b1;
    s_err_clr = 1'b1;
    tick();
    s_rd_en = 1'b0;
    chk("unf_set_wins", 32'(s_unf), 32'd1);
    tick();
    s_err_clr = 1'b0;
    chk("unf_clr", 32'(s_unf), 32'd0);

    // ---------------- asynchronous reset mid-operation ----------------
    for (int i = 1; i <= 3; i++) begin
      s_wr_en = 1'b1;
      s_wr_data = 8'(8'h30 + i);
      tick();
    end
    s_wr_en = 1'b0;
    chk("mid_count", 32'(s_count), 32'd3);
    chk("mid_af",    32'(s_af),    32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(s_count),   32'd0);
    chk("arst_empty", 32'(s_empty),   32'd1);
    chk("arst_af",    32'(s_af),      32'd0);
    chk("arst_ae",    32'(s_ae),      32'd1);
    chk("arst_rdata", 32'(s_rd_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    s_wr_en = 1'b1;
    s_wr_data = 8'h99;
    tick();
    s_wr_en = 1'b0;
    s_rd_en = 1'b1;
    tick();
    s_rd_en = 1'b0;
    chk("post_rst_data",  32'(s_rd_data), 32'h99);
    chk("post_rst_empty", 32'(s_empty),   32'd1);

    // ---------------- FWFT mode ----------------
    chk("fwft_idle_empty", 32'(f_empty), 32'd1);
    f_wr_en = 1'b1;
    f_wr_data = 8'h3C;
    tick();
    f_wr_en = 1'b0;
    chk("fwft_empty_fall", 32'(f_empty),   32'd0);
    chk("fwft_data",       32'(f_rd_data), 32'h3C);
    chk("fwft_count",      32'(f_count),   32'd1);
    tick();
    chk("fwft_hold", 32'(f_rd_data), 32'h3C);
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    chk("fwft_pop_empty", 32'(f_empty), 32'd1);
    chk("fwft_pop_count", 32'(f_count), 32'd0);
    f_wr_en = 1'b1;
    f_wr_data = 8'h5A;
    tick();
    f_wr_data = 8'h6B;
    tick();
    f_wr_en = 1'b0;
    chk("fwft_head", 32'(f_rd_data), 32'h5A);
    f_rd_en = 1'b1;
    tick();
    chk("fwft_next", 32'(f_rd_data), 32'h6B);
    tick();
    f_rd_en = 1'b0;
    chk("fwft_final_empty", 32'(f_empty), 32'd1);
    chk("fwft_no_unf",      32'(f_unf),   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
